// File: rtl/pulp_cluster_package.sv
// Shared constants and types for the cluster peripheral interconnect.
// Holds the pe_slave_arbiter defaults (outstanding credit, aging width and
// threshold) and the arbiter lock-state encoding.
package pulp_cluster_package;

    localparam int PE_ARB_MAX_OUTSTANDING = 2;
    localparam int PE_ARB_AGE_WIDTH       = 4;
    localparam int PE_ARB_AGE_THRESHOLD   = 8;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } pe_arb_state_e;

endpackage

// File: rtl/pe_slave_arbiter_id_fifo.sv
// In-order ID FIFO (stripped-down fifo_v3 behaviour) for pe_slave_arbiter.
// Stores the one-hot requester ID of every granted transaction until its
// response returns. Push while full and pop while empty are ignored.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset (clears all entries)
//   push_i / data_i      write one ID
//   pop_i / data_o       consume head / head ID (valid when !empty_o)
//   full_o, empty_o      occupancy flags
//   usage_o              number of stored IDs
module pe_slave_arbiter_id_fifo #(
    parameter int  DATA_WIDTH = 9,
    parameter int  DEPTH      = 2,
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      usage_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  push_ok;
    logic                  pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_slave_arbiter.sv
// Per-slave-port request scheduler: round-robin arbitration among NB_INPS
// requesters with a grant lock, an outstanding-transaction credit limit and
// in-order response routing via an ID FIFO. Payload muxing lives outside.
// Optional feature macro: PE_ARB_AGING_EN (per-requester age counters; an
// aged requester preempts round-robin when no lock is held).
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   req_i / gnt_o           per-requester request / same-cycle grant
//   sel_o                   selected requester index (payload mux select)
//   slv_req_o / slv_gnt_i   slave port handshake
//   slv_rvalid_i, slv_rid_i slave response and its one-hot ID
//   rsp_valid_o             response valid steered to the expected requester
//   outstanding_o           granted-but-unanswered transactions
//   err_o / err_clr_i       sticky protocol error / clear
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_FREE   | no pending request; selection recomputed every cycle
// ARB_LOCKED | slave stalled a request; lock_idx_q held until handshake
module pe_slave_arbiter
    import pulp_cluster_package::*;
#(
    parameter int  NB_INPS         = 9,
    parameter int  MAX_OUTSTANDING = PE_ARB_MAX_OUTSTANDING,
    parameter int  AGE_WIDTH       = PE_ARB_AGE_WIDTH,
    parameter int  AGE_THRESHOLD   = PE_ARB_AGE_THRESHOLD,
    localparam int SEL_W           = $clog2(NB_INPS),
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NB_INPS-1:0] req_i,
    output logic [NB_INPS-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               slv_req_o,
    input  logic               slv_gnt_i,
    input  logic               slv_rvalid_i,
    input  logic [NB_INPS-1:0] slv_rid_i,
    output logic [NB_INPS-1:0] rsp_valid_o,
    output logic [OUT_W-1:0]   outstanding_o,
    output logic               err_o,
    input  logic               err_clr_i
);

    typedef logic [NB_INPS-1:0] onehot_id_t;

    if (AGE_THRESHOLD >= (1 << AGE_WIDTH)) begin : g_bad_age_threshold
        $error("pe_slave_arbiter: AGE_THRESHOLD must be below 2**AGE_WIDTH");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_outstanding
        $error("pe_slave_arbiter: MAX_OUTSTANDING must be within 1..8");
    end

    pe_arb_state_e state_q, state_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] rr_sel, sel;
    logic             rr_found, lock_valid, handshake;
    logic             fifo_full, fifo_empty, pop, new_err, err_q;
    onehot_id_t       eligible, sel_onehot, head_id;
    logic             aged_found;
    logic [SEL_W-1:0] aged_sel;
    int               idx;

    // Credit check uses the registered occupancy, so a response never
    // frees a credit for a grant in the same cycle.
    assign eligible   = fifo_full ? '0 : req_i;
    assign lock_valid = (state_q == ARB_LOCKED) & eligible[lock_idx_q];

    always_comb begin
        rr_found = 1'b0;
        rr_sel   = rr_ptr_q;
        idx      = 0;
        for (int i = 0; i < NB_INPS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NB_INPS) begin
                idx = idx - NB_INPS;
            end
            if (!rr_found && eligible[SEL_W'(idx)]) begin
                rr_found = 1'b1;
                rr_sel   = SEL_W'(idx);
            end
        end
    end

`ifdef PE_ARB_AGING_EN
    logic [AGE_WIDTH-1:0] age_q [NB_INPS];
    logic [AGE_WIDTH-1:0] age_d [NB_INPS];

    always_comb begin
        aged_found = 1'b0;
        aged_sel   = '0;
        // Descending scan so the lowest aged index wins.
        for (int i = NB_INPS - 1; i >= 0; i--) begin
            if (eligible[i] && age_q[i] >= AGE_WIDTH'(AGE_THRESHOLD)) begin
                aged_found = 1'b1;
                aged_sel   = SEL_W'(i);
            end
        end
        for (int i = 0; i < NB_INPS; i++) begin
            age_d[i] = age_q[i];
            if (!req_i[i] || gnt_o[i]) begin
                age_d[i] = '0;
            end else if (eligible[i] && age_q[i] != {AGE_WIDTH{1'b1}}) begin
                age_d[i] = age_q[i] + AGE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_INPS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign aged_found = 1'b0;
    assign aged_sel   = '0;
`endif

    always_comb begin
        if (lock_valid) begin
            sel = lock_idx_q;
        end else if (aged_found) begin
            sel = aged_sel;
        end else begin
            sel = rr_sel;
        end
    end

    assign slv_req_o  = |eligible;
    assign sel_o      = sel;
    assign handshake  = slv_req_o & slv_gnt_i;
    assign sel_onehot = onehot_id_t'(1) << sel;
    assign gnt_o      = handshake ? sel_onehot : '0;

    always_comb begin
        state_d    = ARB_FREE;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (slv_req_o && !slv_gnt_i) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = sel;
        end
        if (handshake) begin
            rr_ptr_d = (sel == SEL_W'(NB_INPS - 1)) ? '0 : sel + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_FREE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    pe_slave_arbiter_id_fifo #(
        .DATA_WIDTH (NB_INPS),
        .DEPTH      (MAX_OUTSTANDING)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel_onehot),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (outstanding_o)
    );

    // Routing always follows the FIFO head; a wrong slv_rid_i only flags.
    assign pop         = slv_rvalid_i & ~fifo_empty;
    assign rsp_valid_o = pop ? head_id : '0;
    assign new_err     = slv_rvalid_i & (fifo_empty | (slv_rid_i != head_id));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (new_err) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_pe_slave_arbiter.sv
module tb_pe_slave_arbiter;

    logic       clk_i;
    logic       rst_ni;
    logic [8:0] req_i;
    logic [8:0] gnt_o;
    logic [3:0] sel_o;
    logic       slv_req_o;
    logic       slv_gnt_i;
    logic       slv_rvalid_i;
    logic [8:0] slv_rid_i;
    logic [8:0] rsp_valid_o;
    logic [1:0] outstanding_o;
    logic       err_o;
    logic       err_clr_i;

    int tests_run = 0;
    int tests_failed = 0;

    pe_slave_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .sel_o         (sel_o),
        .slv_req_o     (slv_req_o),
        .slv_gnt_i     (slv_gnt_i),
        .slv_rvalid_i  (slv_rvalid_i),
        .slv_rid_i     (slv_rid_i),
        .rsp_valid_o   (rsp_valid_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o),
        .err_clr_i     (err_clr_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal end");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_i        = '0;
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b0;
        slv_rid_i    = '0;
        err_clr_i    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        tests_run++;
        if ({gnt_o, slv_req_o, rsp_valid_o, outstanding_o, err_o} !== 22'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got gnt=%h req=%b rsp=%h out=%0d err=%b, expected all zero",
                     gnt_o, slv_req_o, rsp_valid_o, outstanding_o, err_o);
        end
        tests_run++;
        if (sel_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_sel: got %0d expected 0", sel_o);
        end
        rst_ni = 1'b1;
        step();
        tests_run++;
        if ({gnt_o, slv_req_o, outstanding_o, err_o} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_idle: got gnt=%h req=%b out=%0d err=%b, expected zero",
                     gnt_o, slv_req_o, outstanding_o, err_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_i = 9'h008; slv_gnt_i = 1'b1;
        #4;
        tests_run++;
        if (gnt_o !== 9'h008) begin
            tests_failed++;
            $display("FAIL single_gnt: got %h expected 008", gnt_o);
        end
        tests_run++;
        if (sel_o !== 4'd3) begin
            tests_failed++;
            $display("FAIL single_sel: got %0d expected 3", sel_o);
        end
        step();
        req_i = '0; slv_gnt_i = 1'b0;
        tests_run++;
        if (outstanding_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_out1: got %0d expected 1", outstanding_o);
        end
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h008;
        #4;
        tests_run++;
        if (rsp_valid_o !== 9'h008) begin
            tests_failed++;
            $display("FAIL single_rsp: got %h expected 008", rsp_valid_o);
        end
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got out=%0d err=%b expected out=0 err=0", outstanding_o, err_o);
        end
    endtask

    // Responses return two edges after their grant, so credit runs out
    // every other grant and the bench model predicts the stall cycles.
    task automatic test_round_robin();
        logic       dl0_v, dl1_v;
        logic [8:0] dl0_id, dl1_id, exp_gnt;
        int         exp_out, nxt, ngr;
        do_reset();
        dl0_v = 1'b0; dl1_v = 1'b0; dl0_id = '0; dl1_id = '0;
        exp_out = 0; nxt = 0; ngr = 0;
        req_i = 9'h1FF; slv_gnt_i = 1'b1;
        for (int c = 0; c < 40 && ngr < 10; c++) begin
            slv_rvalid_i = dl0_v; slv_rid_i = dl0_id;
            exp_gnt = (exp_out == 2) ? 9'h000 : (9'h001 << nxt);
            #4;
            tests_run++;
            if (gnt_o !== exp_gnt) begin
                tests_failed++;
                $display("FAIL rr_gnt cycle %0d: got %h expected %h", c, gnt_o, exp_gnt);
            end
            tests_run++;
            if (outstanding_o !== 2'(exp_out)) begin
                tests_failed++;
                $display("FAIL rr_out cycle %0d: got %0d expected %0d", c, outstanding_o, exp_out);
            end
            if (exp_gnt != 9'h000) begin
                nxt = (nxt + 1) % 9;
                ngr++;
            end
            exp_out = exp_out + ((exp_gnt != 9'h000) ? 1 : 0) - (dl0_v ? 1 : 0);
            dl0_v = dl1_v; dl0_id = dl1_id;
            dl1_v = (exp_gnt != 9'h000); dl1_id = exp_gnt;
            step();
        end
        req_i = '0; slv_gnt_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            slv_rvalid_i = dl0_v; slv_rid_i = dl0_id;
            dl0_v = dl1_v; dl0_id = dl1_id; dl1_v = 1'b0; dl1_id = '0;
            step();
        end
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain: got out=%0d err=%b expected out=0 err=0", outstanding_o, err_o);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_i = 9'h003; slv_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            tests_run++;
            if (sel_o !== 4'd0 || gnt_o !== 9'h000 || slv_req_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL lock_hold cycle %0d: got sel=%0d gnt=%h req=%b expected sel=0 gnt=000 req=1",
                         c, sel_o, gnt_o, slv_req_o);
            end
            step();
        end
        slv_gnt_i = 1'b1;
        #4;
        tests_run++;
        if (gnt_o !== 9'h001) begin
            tests_failed++;
            $display("FAIL lock_release: got %h expected 001", gnt_o);
        end
        step();
        #4;
        tests_run++;
        if (gnt_o !== 9'h002) begin
            tests_failed++;
            $display("FAIL lock_next: got %h expected 002", gnt_o);
        end
        step();
        req_i = '0; slv_gnt_i = 1'b0;
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h001;
        step();
        slv_rid_i = 9'h002;
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        // rr_ptr is now 2: lock requester 3, then let requester 2 join;
        // round-robin alone would pick 2, the lock must keep 3.
        req_i = 9'h008;
        step();
        req_i = 9'h00C;
        #4;
        tests_run++;
        if (sel_o !== 4'd3) begin
            tests_failed++;
            $display("FAIL lock_vs_rr: got sel=%0d expected 3", sel_o);
        end
        step();
        slv_gnt_i = 1'b1;
        #4;
        tests_run++;
        if (gnt_o !== 9'h008) begin
            tests_failed++;
            $display("FAIL lock_vs_rr_gnt: got %h expected 008", gnt_o);
        end
        step();
        #4;
        tests_run++;
        if (gnt_o !== 9'h004) begin
            tests_failed++;
            $display("FAIL lock_wrap_gnt: got %h expected 004", gnt_o);
        end
        step();
        req_i = '0; slv_gnt_i = 1'b0;
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h008;
        #4;
        tests_run++;
        if (rsp_valid_o !== 9'h008) begin
            tests_failed++;
            $display("FAIL lock_rsp0: got %h expected 008", rsp_valid_o);
        end
        step();
        slv_rid_i = 9'h004;
        #4;
        tests_run++;
        if (rsp_valid_o !== 9'h004) begin
            tests_failed++;
            $display("FAIL lock_rsp1: got %h expected 004", rsp_valid_o);
        end
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_done: got out=%0d err=%b expected out=0 err=0", outstanding_o, err_o);
        end
    endtask

    task automatic test_errors();
        do_reset();
        req_i = 9'h004; slv_gnt_i = 1'b1;
        step();
        req_i = '0; slv_gnt_i = 1'b0;
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h010;
        #4;
        tests_run++;
        if (rsp_valid_o !== 9'h004 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mismatch_route: got rsp=%h err=%b expected rsp=004 err=0", rsp_valid_o, err_o);
        end
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (err_o !== 1'b1 || outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL mismatch_err: got err=%b out=%0d expected err=1 out=0", err_o, outstanding_o);
        end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: got %b expected 0", err_o);
        end
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h001;
        #4;
        tests_run++;
        if (rsp_valid_o !== 9'h000) begin
            tests_failed++;
            $display("FAIL orphan_rsp: got %h expected 000", rsp_valid_o);
        end
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (err_o !== 1'b1 || outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL orphan_err: got err=%b out=%0d expected err=1 out=0", err_o, outstanding_o);
        end
        err_clr_i = 1'b1; slv_rvalid_i = 1'b1; slv_rid_i = 9'h001;
        step();
        err_clr_i = 1'b0; slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_clr_vs_new: got %b expected 1", err_o);
        end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear2: got %b expected 0", err_o);
        end
    endtask

    // Requester 8 waits behind a lock on 0 long enough to age; afterwards
    // rr_ptr points at 1, so only aging lets 8 win the next arbitration.
    task automatic test_aging();
        logic [8:0] exp_second;
`ifdef PE_ARB_AGING_EN
        exp_second = 9'h100;
`else
        exp_second = 9'h002;
`endif
        do_reset();
        req_i = 9'h101; slv_gnt_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
        end
        slv_gnt_i = 1'b1;
        #4;
        tests_run++;
        if (gnt_o !== 9'h001) begin
            tests_failed++;
            $display("FAIL aging_lock_gnt: got %h expected 001", gnt_o);
        end
        step();
        req_i = 9'h103;
        #4;
        tests_run++;
        if (gnt_o !== exp_second) begin
            tests_failed++;
            $display("FAIL aging_gnt: got %h expected %h", gnt_o, exp_second);
        end
        step();
        req_i = '0; slv_gnt_i = 1'b0;
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h001;
        step();
        slv_rid_i = exp_second;
        #4;
        tests_run++;
        if (rsp_valid_o !== exp_second) begin
            tests_failed++;
            $display("FAIL aging_rsp: got %h expected %h", rsp_valid_o, exp_second);
        end
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL aging_done: got out=%0d err=%b expected out=0 err=0", outstanding_o, err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_i = 9'h003; slv_gnt_i = 1'b1;
        step();
        step();
        #4;
        tests_run++;
        if (outstanding_o !== 2'd2 || slv_req_o !== 1'b0 || gnt_o !== 9'h000) begin
            tests_failed++;
            $display("FAIL credit_block: got out=%0d req=%b gnt=%h expected out=2 req=0 gnt=000",
                     outstanding_o, slv_req_o, gnt_o);
        end
        req_i = '0; slv_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({gnt_o, slv_req_o, rsp_valid_o, outstanding_o, err_o} !== 22'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got gnt=%h req=%b rsp=%h out=%0d err=%b expected zero",
                     gnt_o, slv_req_o, rsp_valid_o, outstanding_o, err_o);
        end
        step();
        rst_ni = 1'b1;
        slv_rvalid_i = 1'b1; slv_rid_i = 9'h001;
        #4;
        tests_run++;
        if (rsp_valid_o !== 9'h000) begin
            tests_failed++;
            $display("FAIL midreset_rsp: got %h expected 000", rsp_valid_o);
        end
        step();
        slv_rvalid_i = 1'b0; slv_rid_i = '0;
        tests_run++;
        if (err_o !== 1'b1 || outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL midreset_orphan: got err=%b out=%0d expected err=1 out=0", err_o, outstanding_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_errors();
        test_aging();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pe_slave_arbiter.md
# pe_slave_arbiter

Per-slave-port request scheduler for the cluster peripheral interconnect. It shares one peripheral slave port (event unit, timer, DMA config, HWPE config, ...) between NB_INPS requesters: NB_CORES core ports plus NB_MPERIPHS master ports. It uses round-robin arbitration with optional aging. It also enforces an outstanding-transaction credit limit and tracks granted requester IDs in order so that responses are checked and steered back. Request/response payload muxing stays outside; this block drives only select, handshake and routing signals.

## Interface
- NB_INPS, 9, number of requesters (cores + master peripherals)
- MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (1..8)
- AGE_WIDTH, 4, width of per-requester aging counter
- AGE_THRESHOLD, 8, age at which a requester preempts round-robin (< 2^AGE_WIDTH)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NB_INPS  per-requester request (periph bus req)
- gnt_o  out  NB_INPS  per-requester grant, one-hot or zero
- sel_o  out  $clog2(NB_INPS)  index of selected requester, drives request payload mux
- slv_req_o  out  1  request to slave port
- slv_gnt_i  in  1  slave grant
- slv_rvalid_i  in  1  slave response valid
- slv_rid_i  in  NB_INPS  one-hot ID returned with response
- rsp_valid_o  out  NB_INPS  per-requester response valid, routed by expected ID
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current credit usage
- err_o  out  1  sticky protocol error (ID mismatch or orphan response)
- err_clr_i  in  1  clears err_o

## Operation
- Eligible set: req_i masked by credit. If outstanding == MAX_OUTSTANDING (registered value), slv_req_o = 0 and gnt_o = 0.
- Selection: round-robin starting at rr_ptr. rr_ptr advances to (granted index + 1) mod NB_INPS on each handshake (slv_req_o & slv_gnt_i).
- Lock: if slv_req_o = 1 and slv_gnt_i = 0, the selection is registered and held until the handshake. An aged requester does not override a locked selection. A locked requester dropping req_i releases the lock; the bus protocol forbids this, and the block does not flag it.
- gnt_o[sel] = slv_req_o & slv_gnt_i (combinational, same cycle).
- Each handshake pushes the one-hot ID of sel into an in-order ID FIFO of depth MAX_OUTSTANDING and increments outstanding.
- slv_rvalid_i pops the FIFO and decrements outstanding. rsp_valid_o = FIFO head one-hot.
  - If slv_rid_i ≠ head: err_o is set and routing still follows the head.
  - If slv_rvalid_i arrives with the FIFO empty: err_o is set, rsp_valid_o = 0, and the counter does not underflow.
- Handshake and response in the same cycle: push and pop together, outstanding unchanged.
- err_clr_i has priority below a new error in the same cycle, so the error stays set.

## Timing
- Request to slave: 0 cycles (req_i → slv_req_o combinational). Grant is combinational.
- Response routing: 0 cycles (slv_rvalid_i → rsp_valid_o).
- A credit freed by a response is usable from the next cycle only. There is no rvalid → gnt combinational path.
- Reset values: rr_ptr = 0, lock = 0, ages = 0, FIFO empty, outstanding_o = 0, err_o = 0, gnt_o = 0, slv_req_o = 0, rsp_valid_o = 0.
- Reset mid-operation drops all tracked IDs. Responses arriving after reset are orphans and set err_o.

## Configuration
- PE_ARB_AGING_EN defined:
  - Each requester has an age counter that increments (saturating at 2^AGE_WIDTH−1) every cycle it requests and is eligible but not granted. It clears on its grant or when its req_i is low.
  - When no lock is held, the lowest-index requester with age ≥ AGE_THRESHOLD wins over round-robin. rr_ptr still advances past it.
- PE_ARB_AGING_EN undefined: no age counters, pure round-robin plus lock.

## Structure
- The following go in pulp_cluster_package:
  - PE_ARB_MAX_OUTSTANDING default
  - aging constants
  - an onehot-ID typedef parameterised through NB_INPS at use site
- Sub-module: common_cells fifo_v3 as the ID FIFO (DATA_WIDTH = NB_INPS, DEPTH = MAX_OUTSTANDING), with full/empty driving the credit logic.
- Use onehot_to_bin for sel_o derivation where needed.

## Test plan
- Single requester: req_i[3] = 1 with slv_gnt_i = 1 → gnt_o = 0x008 the same cycle, outstanding 0 → 1. Response with rid 0x008 → rsp_valid_o = 0x008, outstanding back to 0, err_o = 0.
- All 9 requesting, gnt always 1, responses 1 cycle later, MAX_OUTSTANDING = 2 → grant order 0,1,...,8,0. No grant in cycles where outstanding = 2.
- Lock: req_i = 0x003, slv_gnt_i low for 3 cycles → sel_o stays 0 for all 3 cycles. Then gnt → gnt_o = 0x001, and the next grant goes to 1.
- Mismatch/orphan: expected head 0x004, rid = 0x010 → err_o = 1 next cycle, rsp_valid_o = 0x004. rvalid with empty FIFO → err_o = 1, outstanding stays 0. err_clr_i → 0.
- Aging (PE_ARB_AGING_EN, threshold 8): requester 8 blocked by credit exhaustion while 0..7 are served → after age reaches 8 it wins the next unlocked arbitration regardless of rr_ptr.
- Reset mid-operation with outstanding = 2 → all outputs at reset values. A subsequent rvalid sets err_o.
